z80_bus_mem: RTL and testbench
==============================

# z80_bus_mem

Memory target on the Z80 system bus. It decodes memory read and write cycles from the CPU's `MREQ_L`/`RD_L`/`WR_L` strobes and inserts a programmable number of wait states through `WAIT_L`. It drives the shared tri-state `data_bus` on reads and commits `data_bus` into an internal byte array on writes. It sits directly downstream of the z80 core on `addr_bus`/`data_bus` and replaces the behavioural memory model in system benches. A side-band load port lets benches preload programs.

## Interface
- `ADDR_W`, 12: implemented address bits. Depth is 2^ADDR_W bytes. `addr_bus[ADDR_W-1:0]` indexes the array; upper bits are ignored, so the array mirrors.
- `WAIT_STATES`, 1: number of `WAIT_L`-low cycles per access. Legal range is 0..15.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `addr_bus`  in  16  CPU address.
- `data_bus`  inout  8  shared CPU data bus. Driven only during a read data phase; otherwise `'z`.
- `MREQ_L`  in  1  memory request, active low.
- `RD_L`  in  1  read strobe, active low.
- `WR_L`  in  1  write strobe, active low.
- `RFSH_L`  in  1  refresh indicator, active low. Cycles with `RFSH_L=0` are ignored.
- `M1_L`  in  1  opcode-fetch indicator. Counted only; it does not change the access.
- `WAIT_L`  out  1  wait request to the CPU, active low.
- `out_value`  out  8  registered read-data latch (debug/monitor).
- `ld_en`  in  1  bench preload write enable.
- `ld_addr`  in  ADDR_W  preload address.
- `ld_data`  in  8  preload data.
- `fetch_cnt`  out  16  number of completed M1 reads; wraps modulo 2^16.

## Operation
- **Cycle detect (`req`):** `MREQ_L==0 && RFSH_L==1 && (RD_L==0 || WR_L==0)`, sampled at the rising edge.
  - If `RD_L` and `WR_L` are both low, the access is treated as a read.
- **FSM states:** `IDLE`, `WAIT`, `ACTIVE`, `HOLD`.
- **IDLE:**
  - On `req` with `WAIT_STATES>0`: go to `WAIT`, load `wcnt=WAIT_STATES-1`, set `WAIT_L<=0`, latch `is_rd` and `addr_q`.
  - On `req` with `WAIT_STATES==0`: perform the access (below) and go to `ACTIVE`.
- **WAIT:**
  - If `MREQ_L` rises: abort to `IDLE`, set `WAIT_L<=1`, no write, `out_value` unchanged.
  - Else if `wcnt==0`: perform the access, set `WAIT_L<=1`, go to `ACTIVE`.
  - Else: decrement `wcnt`.
- **Access, read:** `out_value<=mem[addr_q]`. If `M1_L==0` at this edge, `fetch_cnt` increments.
- **Access, write:** `mem[addr_q]<=data_bus`, sampled at the access edge.
- **ACTIVE:**
  - `data_bus = out_value` whenever `is_rd && MREQ_L==0 && RD_L==0`. This enable is combinational, so the bus releases in the same cycle the strobe rises.
  - Go to `HOLD` next edge.
- **HOLD:** stay until `MREQ_L==1`, then go to `IDLE`. A strobe held across several edges never triggers a second access.
- **Load port:** `ld_en` writes `mem[ld_addr]<=ld_data` in any state. If a bus write commits to the same address on the same edge, the bus write wins.
- **Arithmetic:** `wcnt` is 4 bits. `fetch_cnt` is 16 bits and wraps `ffff->0000`.

## Timing
- **Reset values:**
  - `WAIT_L=1`, `out_value=00`, `fetch_cnt=0000`, state `IDLE`, `data_bus` released.
  - Memory contents are not cleared.
- **Reset mid-access:** immediately returns to `IDLE` and releases the bus. A pending write is dropped.
- **Read latency:**
  - `req` sampled at edge N; data valid on `out_value`/`data_bus` after edge N+`WAIT_STATES`.
  - `WAIT_L` is low from edge N to edge N+`WAIT_STATES`, i.e. exactly `WAIT_STATES` cycles.
- **Write:** the array updates at edge N+`WAIT_STATES` with `data_bus` sampled at that edge. The CPU must hold data through it.
- **Back-to-back accesses:** need `MREQ_L` high for at least one sampled edge between them. The minimum access period is `WAIT_STATES`+3 cycles.
- **Refresh cycles:** no `WAIT_L`, no bus drive, no array access.

## Test plan
- **Preload and read:** preload `mem[0x010]=0x3E` via `ld_en`, then a read cycle at `addr_bus=0x0010` with `WAIT_STATES=1` → `WAIT_L` low exactly 1 cycle, `data_bus=3E` while `RD_L=0`, `'z` after `RD_L` rises.
- **Write then read, with mirroring:** write `0xA5` to `0x0123`, then read `0x1123` (mirror, `ADDR_W=12`) → `A5`.
- **Refresh ignored:** `MREQ_L=0`, `RD_L=0`, `RFSH_L=0` for 3 cycles → `WAIT_L` stays 1, `data_bus` `'z`, `out_value` unchanged.
- **Abort:** start a write with `WAIT_STATES=3`, raise `MREQ_L` after 1 wait cycle → array unchanged, `WAIT_L=1` next edge, FSM in `IDLE`.
- **Reset mid-read:** assert `rst` mid-read while `data_bus` is driven → bus `'z` and `WAIT_L=1` asynchronously; preloaded data survives a subsequent read.
- **Fetch counter and collision:**
  - 3 M1 reads plus 1 non-M1 read → `fetch_cnt=0003`.
  - Simultaneous `ld_en` and bus write to `0x020` (`ld_data=11`, bus `22`) → `mem[0x020]=22`.

Source files
------------

// File: rtl/z80_bus_mem.sv
// Z80 memory target: strobe-decoded read/write with a fixed number of WAIT_L cycles, tri-state data drive.
// Read data valid WAIT_STATES edges after the request edge; backpressure to the CPU is WAIT_L only.
module z80_bus_mem #(
   parameter int ADDR_W      = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       addr_bus,
   inout  wire  [7:0]        data_bus,
   input  logic              MREQ_L,
   input  logic              RD_L,
   input  logic              WR_L,
   input  logic              RFSH_L,
   input  logic              M1_L,
   output logic              WAIT_L,
   output logic [7:0]        out_value,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [7:0]        ld_data,
   output logic [15:0]       fetch_cnt
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [3:0] WCNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ACTIVE,
      ST_HOLD
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic              wait_l_q, wait_l_d;
   logic              is_rd_q, is_rd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        out_value_q, out_value_d;
   logic [15:0]       fetch_cnt_q, fetch_cnt_d;

   logic [7:0]        mem_q [0:DEPTH-1];

   logic              req;
   logic              acc;
   logic              acc_rd;
   logic [ADDR_W-1:0] acc_addr;
   logic              mem_we;
   logic              drive_en;
   logic              unused_addr_hi;

   assign unused_addr_hi = &{1'b0, addr_bus[15:ADDR_W]};

   assign req = !MREQ_L && RFSH_L && (!RD_L || !WR_L);

   always_comb begin
      state_d     = state_q;
      wcnt_d      = wcnt_q;
      wait_l_d    = wait_l_q;
      is_rd_d     = is_rd_q;
      addr_d      = addr_q;
      out_value_d = out_value_q;
      fetch_cnt_d = fetch_cnt_q;
      acc         = 1'b0;
      acc_rd      = is_rd_q;
      acc_addr    = addr_q;

      case (state_q)
         ST_IDLE: begin
            if (req) begin
               is_rd_d = !RD_L;
               addr_d  = addr_bus[ADDR_W-1:0];
               if (WAIT_STATES > 0) begin
                  state_d  = ST_WAIT;
                  wcnt_d   = WCNT_INIT;
                  wait_l_d = 1'b0;
               end else begin
                  // Zero wait states: access uses the live bus, the latches are not valid yet.
                  acc      = 1'b1;
                  acc_rd   = !RD_L;
                  acc_addr = addr_bus[ADDR_W-1:0];
                  state_d  = ST_ACTIVE;
               end
            end
         end
         ST_WAIT: begin
            if (MREQ_L) begin
               state_d  = ST_IDLE;
               wait_l_d = 1'b1;
            end else if (wcnt_q == 4'd0) begin
               acc      = 1'b1;
               wait_l_d = 1'b1;
               state_d  = ST_ACTIVE;
            end else begin
               wcnt_d = wcnt_q - 4'd1;
            end
         end
         ST_ACTIVE: state_d = ST_HOLD;
         ST_HOLD: begin
            if (MREQ_L) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (acc && acc_rd) begin
         out_value_d = mem_q[acc_addr];
         if (!M1_L) begin
            fetch_cnt_d = fetch_cnt_q + 16'd1;
         end
      end
   end

   assign mem_we = acc && !acc_rd && !rst;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         wcnt_q      <= 4'd0;
         wait_l_q    <= 1'b1;
         is_rd_q     <= 1'b0;
         addr_q      <= '0;
         out_value_q <= 8'h00;
         fetch_cnt_q <= 16'h0000;
      end else begin
         state_q     <= state_d;
         wcnt_q      <= wcnt_d;
         wait_l_q    <= wait_l_d;
         is_rd_q     <= is_rd_d;
         addr_q      <= addr_d;
         out_value_q <= out_value_d;
         fetch_cnt_q <= fetch_cnt_d;
      end
   end

   // Array is deliberately not reset; the later assignment gives the bus write priority over preload.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem_q[ld_addr] <= ld_data;
      end
      if (mem_we) begin
         mem_q[acc_addr] <= data_bus;
      end
   end

   // Drive continues into HOLD so a CPU holding RD_L past the access edge still sees the data.
   assign drive_en  = ((state_q == ST_ACTIVE) || (state_q == ST_HOLD)) && is_rd_q && !MREQ_L && !RD_L;
   assign data_bus  = drive_en ? out_value_q : 8'hzz;

   assign WAIT_L    = wait_l_q;
   assign out_value = out_value_q;
   assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_z80_bus_mem.sv
// Bench for z80_bus_mem: CPU-style bus cycles checked against a byte-array reference model.
module tb_z80_bus_mem;

   localparam int AW = 12;
   localparam int WS = 3;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   addr_bus;
   wire  [7:0]    data_bus;
   logic          mreq_l, rd_l, wr_l, rfsh_l, m1_l;
   logic          wait_l;
   logic [7:0]    out_value;
   logic          ld_en;
   logic [AW-1:0] ld_addr;
   logic [7:0]    ld_data;
   logic [15:0]   fetch_cnt;
   logic          tb_oe;
   logic [7:0]    tb_dat;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0]  ref_mem [0:(1<<AW)-1];
   logic [7:0]  ref_out;
   logic [15:0] ref_fetch;

   assign data_bus = tb_oe ? tb_dat : 8'hzz;
   for (genvar i = 0; i < 8; i++) begin : g_pu
      pullup (data_bus[i]);
   end

   always #5 clk = ~clk;

   z80_bus_mem #(.ADDR_W(AW), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
      .MREQ_L(mreq_l), .RD_L(rd_l), .WR_L(wr_l), .RFSH_L(rfsh_l), .M1_L(m1_l),
      .WAIT_L(wait_l), .out_value(out_value),
      .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .fetch_cnt(fetch_cnt)
   );

   task automatic idle_bus();
      mreq_l = 1'b1; rd_l = 1'b1; wr_l = 1'b1; rfsh_l = 1'b1; m1_l = 1'b1; tb_oe = 1'b0;
   endtask

   task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
      @(negedge clk);
      ld_en = 1'b1; ld_addr = a; ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic do_read(input logic [15:0] a, input logic m1, input string tag);
      int n;
      logic [7:0] exp;
      exp = ref_mem[a[AW-1:0]];
      @(negedge clk);
      addr_bus = a; m1_l = ~m1; mreq_l = 1'b0; rd_l = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (wait_l) break;
         n++;
      end
      ref_out = exp;
      if (m1) ref_fetch = ref_fetch + 16'd1;
      n_tests++;
      if (n != WS) begin n_fail++; $display("FAIL %s rd_wait_cycles: got %0d expected %0d", tag, n, WS); end
      n_tests++;
      if (data_bus !== exp) begin n_fail++; $display("FAIL %s rd_bus: got %h expected %h", tag, data_bus, exp); end
      n_tests++;
      if (out_value !== exp) begin n_fail++; $display("FAIL %s rd_out_value: got %h expected %h", tag, out_value, exp); end
      n_tests++;
      if (fetch_cnt !== ref_fetch) begin n_fail++; $display("FAIL %s rd_fetch_cnt: got %h expected %h", tag, fetch_cnt, ref_fetch); end
      @(posedge clk); #1;
      n_tests++;
      if (data_bus !== exp) begin n_fail++; $display("FAIL %s hold_bus: got %h expected %h", tag, data_bus, exp); end
      n_tests++;
      if (fetch_cnt !== ref_fetch) begin n_fail++; $display("FAIL %s hold_no_reaccess: got %h expected %h", tag, fetch_cnt, ref_fetch); end
      @(negedge clk);
      mreq_l = 1'b1; rd_l = 1'b1; m1_l = 1'b1;
      #1;
      n_tests++;
      if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL %s release_bus: got %h expected released (FF)", tag, data_bus); end
      @(posedge clk);
      @(posedge clk);
   endtask

   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input logic collide,
                           input logic [7:0] ldd, input string tag);
      int n;
      @(negedge clk);
      addr_bus = a; tb_dat = d; tb_oe = 1'b1; mreq_l = 1'b0; wr_l = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (wait_l) break;
         n++;
         if (collide && n == WS - 1) begin
            @(negedge clk);
            ld_en = 1'b1; ld_addr = a[AW-1:0]; ld_data = ldd;
         end
      end
      ld_en = 1'b0;
      ref_mem[a[AW-1:0]] = d;
      n_tests++;
      if (n != WS) begin n_fail++; $display("FAIL %s wr_wait_cycles: got %0d expected %0d", tag, n, WS); end
      @(negedge clk);
      mreq_l = 1'b1; wr_l = 1'b1; tb_oe = 1'b0;
      @(posedge clk);
      @(posedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      idle_bus();
      addr_bus = 16'h0000; tb_dat = 8'h00; ld_en = 1'b0; ld_addr = '0; ld_data = 8'h00;
      ref_out = 8'h00; ref_fetch = 16'h0000;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (wait_l !== 1'b1) begin n_fail++; $display("FAIL reset_wait_l: got %b expected 1", wait_l); end
      n_tests++;
      if (out_value !== 8'h00) begin n_fail++; $display("FAIL reset_out_value: got %h expected 00", out_value); end
      n_tests++;
      if (fetch_cnt !== 16'h0000) begin n_fail++; $display("FAIL reset_fetch_cnt: got %h expected 0000", fetch_cnt); end
      n_tests++;
      if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL reset_bus: got %h expected released (FF)", data_bus); end
      rst = 1'b0;
   endtask

   task automatic test_preload_read();
      preload(12'h010, 8'h3E);
      do_read(16'h0010, 1'b0, "preload_read");
   endtask

   task automatic test_write_mirror();
      do_write(16'h0123, 8'hA5, 1'b0, 8'h00, "write_0123");
      do_read(16'h1123, 1'b0, "mirror_1123");
   endtask

   task automatic test_refresh();
      @(negedge clk);
      addr_bus = 16'h0010; mreq_l = 1'b0; rd_l = 1'b0; rfsh_l = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         n_tests++;
         if (wait_l !== 1'b1) begin n_fail++; $display("FAIL refresh_wait_l[%0d]: got %b expected 1", c, wait_l); end
         n_tests++;
         if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL refresh_bus[%0d]: got %h expected released (FF)", c, data_bus); end
         n_tests++;
         if (out_value !== ref_out) begin n_fail++; $display("FAIL refresh_out_value[%0d]: got %h expected %h", c, out_value, ref_out); end
      end
      @(negedge clk);
      idle_bus();
      @(posedge clk);
   endtask

   task automatic test_abort();
      preload(12'h200, 8'h5A);
      @(negedge clk);
      addr_bus = 16'h0200; tb_dat = 8'hC3; tb_oe = 1'b1; mreq_l = 1'b0; wr_l = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (wait_l !== 1'b0) begin n_fail++; $display("FAIL abort_wait_low: got %b expected 0", wait_l); end
      @(negedge clk);
      idle_bus();
      @(posedge clk); #1;
      n_tests++;
      if (wait_l !== 1'b1) begin n_fail++; $display("FAIL abort_wait_release: got %b expected 1", wait_l); end
      do_read(16'h0200, 1'b0, "abort_readback");
   endtask

   task automatic test_reset_mid_read();
      preload(12'h300, 8'h77);
      @(negedge clk);
      addr_bus = 16'h0300; mreq_l = 1'b0; rd_l = 1'b0;
      @(posedge clk); #1;
      n_tests++;
      if (wait_l !== 1'b0) begin n_fail++; $display("FAIL rstwait_pre: got %b expected 0", wait_l); end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (wait_l !== 1'b1) begin n_fail++; $display("FAIL rstwait_async_wait_l: got %b expected 1", wait_l); end
      @(negedge clk);
      idle_bus();
      rst = 1'b0;
      ref_out = 8'h00; ref_fetch = 16'h0000;
      n_tests++;
      if (out_value !== 8'h00) begin n_fail++; $display("FAIL rstwait_out_value: got %h expected 00", out_value); end
      @(negedge clk);
      addr_bus = 16'h0300; mreq_l = 1'b0; rd_l = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (wait_l) break;
      end
      n_tests++;
      if (data_bus !== 8'h77) begin n_fail++; $display("FAIL rstact_pre_bus: got %h expected 77", data_bus); end
      #2 rst = 1'b1;
      #1;
      n_tests++;
      if (data_bus !== 8'hFF) begin n_fail++; $display("FAIL rstact_async_bus: got %h expected released (FF)", data_bus); end
      n_tests++;
      if (wait_l !== 1'b1) begin n_fail++; $display("FAIL rstact_wait_l: got %b expected 1", wait_l); end
      @(negedge clk);
      idle_bus();
      @(negedge clk);
      rst = 1'b0;
      do_read(16'h0300, 1'b0, "after_reset_read");
   endtask

   task automatic test_fetch_collision();
      for (int i = 0; i < 4; i++) preload(AW'(12'h040 + i), 8'(8'h90 + i));
      for (int i = 0; i < 4; i++) do_read(16'(16'h0040 + i), (i != 2), "fetch_read");
      n_tests++;
      if (fetch_cnt !== 16'h0003) begin n_fail++; $display("FAIL fetch_cnt_three: got %h expected 0003", fetch_cnt); end
      do_write(16'h0020, 8'h22, 1'b1, 8'h11, "collision_write");
      do_read(16'h0020, 1'b0, "collision_read");
      n_tests++;
      if (out_value !== 8'h22) begin n_fail++; $display("FAIL collision_winner: got %h expected 22", out_value); end
   endtask

   task automatic test_random();
      logic [AW-1:0] pool [0:7];
      logic [15:0]   a;
      for (int i = 0; i < 8; i++) begin
         pool[i] = AW'($urandom_range(0, (1 << AW) - 1));
         preload(pool[i], 8'($urandom));
      end
      for (int it = 0; it < 30; it++) begin
         a = {4'($urandom), pool[$urandom_range(0, 7)]};
         if ($urandom_range(0, 1) == 0)
            do_write(a, 8'($urandom), 1'b0, 8'h00, "rand_write");
         else
            do_read(a, 1'($urandom), "rand_read");
      end
   endtask

   initial begin
      test_reset();
      test_preload_read();
      test_write_mirror();
      test_refresh();
      test_abort();
      test_reset_mid_read();
      test_fetch_collision();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
